// File: rtl/rgb_pattern_sequencer_pkg.sv
// Shared definitions for the RGB pattern sequencer: default sizes,
// colour-word channel layout and sequencer state encoding.
package rgb_pattern_sequencer_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;
  localparam int unsigned DEPTH_DEF    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // Colour word layout is {red, green, blue}, each p bits wide.
  function automatic int unsigned red_lsb(input int unsigned p);
    return 2 * p;
  endfunction

  function automatic int unsigned green_lsb(input int unsigned p);
    return p;
  endfunction

  function automatic int unsigned blue_lsb(input int unsigned p);
    return 0;
  endfunction

endpackage

// File: rtl/rgb_pattern_sequencer_pwm_core.sv
// Three-channel PWM core: free-running counter, shadow-to-active duty
// transfer on the last count of each period, registered compares.
module rgb_pwm_core
  import rgb_pattern_sequencer_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [3*PWM_BITS-1:0]   shadow_i,
  output logic                    pwm_r_o,
  output logic                    pwm_g_o,
  output logic                    pwm_b_o
);

  localparam int unsigned R_LSB = red_lsb(PWM_BITS);
  localparam int unsigned G_LSB = green_lsb(PWM_BITS);
  localparam int unsigned B_LSB = blue_lsb(PWM_BITS);

  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [3*PWM_BITS-1:0] active_q, active_d;
  logic [2:0]            pwm_q, pwm_d;

  // Next counter value, duty adoption at wrap, and compare results.
  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    active_d = active_q;
    if (cnt_q == '1) begin
      active_d = shadow_i;
    end
    pwm_d[2] = (cnt_q < active_q[R_LSB +: PWM_BITS]);
    pwm_d[1] = (cnt_q < active_q[G_LSB +: PWM_BITS]);
    pwm_d[0] = (cnt_q < active_q[B_LSB +: PWM_BITS]);
  end

  // Counter, active duties and compare outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      active_q <= '0;
      pwm_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_r_o = pwm_q[2];
  assign pwm_g_o = pwm_q[1];
  assign pwm_b_o = pwm_q[0];

endmodule

// File: rtl/rgb_pattern_sequencer.sv
// RGB pattern sequencer: colour table, hold-time sequencer FSM and LED
// enable, feeding the PWM core that drives the RGB LED current driver.
module rgb_pattern_sequencer
  import rgb_pattern_sequencer_pkg::*;
#(
  parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
  parameter int unsigned HOLD_BITS = 24,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned IDX_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [IDX_BITS:0]     seq_len,
  input  logic [HOLD_BITS-1:0]  hold_cycles,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [IDX_BITS-1:0]   cfg_addr,
  input  logic [3*PWM_BITS-1:0] cfg_rgb,
  output logic                  pwm_r,
  output logic                  pwm_g,
  output logic                  pwm_b,
  output logic                  led_en,
  output logic [IDX_BITS-1:0]   cur_idx,
  output logic                  step
);

  localparam logic [IDX_BITS:0] DEPTH_W = (IDX_BITS+1)'(DEPTH);

  logic [3*PWM_BITS-1:0] tbl_q [DEPTH];

  seq_state_e            state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [HOLD_BITS-1:0]  hold_q, hold_d;
  logic [3*PWM_BITS-1:0] shadow_q, shadow_d;
  logic                  led_en_q, led_en_d;
  logic                  step_q, step_d;
  logic                  cfg_ready_q;

  logic [IDX_BITS:0]     eff_last;
  logic [IDX_BITS-1:0]   nxt_idx;
  logic [IDX_BITS-1:0]   load_idx;
  logic [3*PWM_BITS-1:0] load_val;
  logic                  pwm_r_raw, pwm_g_raw, pwm_b_raw;

  // Clamp seq_len into 1..DEPTH, pick the next index and the entry to load.
  // The >= compare also wraps an index left beyond a shortened sequence.
  always_comb begin
    if (seq_len == '0) begin
      eff_last = '0;
    end else if (seq_len > DEPTH_W) begin
      eff_last = DEPTH_W - 1'b1;
    end else begin
      eff_last = seq_len - 1'b1;
    end
    if ({1'b0, idx_q} >= eff_last) begin
      nxt_idx = '0;
    end else begin
      nxt_idx = idx_q + 1'b1;
    end
    load_idx = (state_q == RUN) ? nxt_idx : '0;
    load_val = (cfg_valid && (cfg_addr == load_idx)) ? cfg_rgb : tbl_q[load_idx];
  end

  // Sequencer next-state and register updates.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    led_en_d = led_en_q;
    step_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        led_en_d = 1'b0;
        shadow_d = '0;
        idx_d    = '0;
        if (en) begin
          state_d  = RUN;
          shadow_d = load_val;
          hold_d   = hold_cycles;
          led_en_d = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d  = IDLE;
          shadow_d = '0;
          led_en_d = 1'b0;
          idx_d    = '0;
          hold_d   = '0;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          idx_d    = nxt_idx;
          shadow_d = load_val;
          hold_d   = hold_cycles;
          step_d   = 1'b1;
        end
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      shadow_q    <= '0;
      led_en_q    <= 1'b0;
      step_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      shadow_q    <= shadow_d;
      led_en_q    <= led_en_d;
      step_q      <= step_d;
      cfg_ready_q <= 1'b1;
    end
  end

  // Colour table writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_valid) begin
      tbl_q[cfg_addr] <= cfg_rgb;
    end
  end

  rgb_pwm_core #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk_i    (clk),
    .rst_i    (rst),
    .shadow_i (shadow_q),
    .pwm_r_o  (pwm_r_raw),
    .pwm_g_o  (pwm_g_raw),
    .pwm_b_o  (pwm_b_raw)
  );

  // Outputs go dark immediately with led_en; active duties clear at the wrap.
  assign pwm_r     = pwm_r_raw & led_en_q;
  assign pwm_g     = pwm_g_raw & led_en_q;
  assign pwm_b     = pwm_b_raw & led_en_q;
  assign led_en    = led_en_q;
  assign cur_idx   = idx_q;
  assign step      = step_q;
  assign cfg_ready = cfg_ready_q;

endmodule
